// File: rtl/unified_memory_arbiter_if.sv
// Requester and backing-memory signal bundle for unified_memory_arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface unified_memory_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [31:0]           if_rdata;
   logic                  if_err;

   logic                  dm_req;
   logic                  dm_we;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [31:0]           dm_wdata;
   logic [3:0]            dm_wmask;
   logic                  dm_done;
   logic [31:0]           dm_rdata;
   logic                  dm_err;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wmask;
   logic [31:0]           mem_rdata;
   logic                  mem_ack;

   modport slave (
      input  if_req, if_addr,
      output if_done, if_rdata, if_err,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
      output dm_done, dm_rdata, dm_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_ack
   );

   modport master (
      output if_req, if_addr,
      input  if_done, if_rdata, if_err,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
      input  dm_done, dm_rdata, dm_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; fetch is forced after STARVE_LIMIT consecutive data grants.
module unified_memory_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                            clk,
   input  logic                            reset,
   unified_memory_arbiter_if.slave         bus,
   output logic                            busy
);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TMO_W    = 8;

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_e;

   state_e                state_q, state_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wmask_q, mem_wmask_d;
   logic                  if_done_q, if_done_d, if_err_q, if_err_d;
   logic                  dm_done_q, dm_done_d, dm_err_q, dm_err_d;
   logic [31:0]           if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic                  busy_q, busy_d;

   logic starved;
   logic tmo_hit;
   assign starved = bus.if_req && (starve_q == STARVE_W'(STARVE_LIMIT));
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      if_done_d   = 1'b0;
      if_err_d    = 1'b0;
      dm_done_d   = 1'b0;
      dm_err_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.dm_req && !starved) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               mem_wmask_d = bus.dm_we ? bus.dm_wmask : 4'b0000;
               tmo_d       = '0;
               if (!bus.if_req)
                  starve_d = '0;
               else if (starve_q != STARVE_W'(STARVE_LIMIT))
                  starve_d = starve_q + STARVE_W'(1);
            end else if (bus.if_req) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               mem_wmask_d = 4'b0000;
               tmo_d       = '0;
               starve_d    = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            // Ack and timeout both complete the access; ack wins if both coincide.
            if (bus.mem_ack || tmo_hit) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  if_done_d  = 1'b1;
                  if_err_d   = !bus.mem_ack;
                  if_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'd0;
               end else begin
                  dm_done_d  = 1'b1;
                  dm_err_d   = !bus.mem_ack;
                  dm_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'd0;
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         if_done_q   <= 1'b0;
         if_err_q    <= 1'b0;
         dm_done_q   <= 1'b0;
         dm_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         if_done_q   <= if_done_d;
         if_err_q    <= if_err_d;
         dm_done_q   <= dm_done_d;
         dm_err_q    <= dm_err_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wmask = mem_wmask_q;
   assign bus.if_done   = if_done_q;
   assign bus.if_err    = if_err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.dm_err    = dm_err_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: fetch, store, contention,
// timeout, asynchronous reset mid-access and held-request re-grant.
module tb_unified_memory_arbiter;
   logic clk;
   logic reset;
   logic busy;
   logic auto_ack;
   logic ack_man;
   logic [31:0] rdata_man;
   int n_vec;
   int n_err;

   unified_memory_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   unified_memory_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave),
      .busy (busy)
   );

   // Memory model: either instant ack or manually driven ack/rdata.
   assign bus.mem_ack   = auto_ack ? bus.mem_req : ack_man;
   assign bus.mem_rdata = auto_ack ? (bus.mem_addr ^ 32'hFFFF_0000) : rdata_man;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #23;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
      n_vec++; if ({bus.if_done, bus.dm_done, bus.if_err, bus.dm_err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_done_err: got %b want 0000", {bus.if_done, bus.dm_done, bus.if_err, bus.dm_err}); end
      n_vec++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.if_rdata, bus.dm_rdata); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
   endtask

   task automatic test_fetch();
      bus.if_addr = 32'h0000_0010;
      bus.if_req  = 1'b1;
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL fetch_grant: req=%b addr=%h we=%b busy=%b want 1/10/0/1", bus.mem_req, bus.mem_addr, bus.mem_we, busy); end
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.if_done !== 1'b0) begin
         n_err++; $display("FAIL fetch_hold: req=%b done=%b want 1/0", bus.mem_req, bus.if_done); end
      ack_man = 1'b1; rdata_man = 32'h0000_0013;
      tick();
      ack_man = 1'b0; bus.if_req = 1'b0;
      n_vec++; if (bus.mem_req !== 1'b0 || bus.if_done !== 1'b1 || bus.if_rdata !== 32'h13 || bus.if_err !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL fetch_done: req=%b done=%b rdata=%h err=%b busy=%b want 0/1/13/0/1",
                           bus.mem_req, bus.if_done, bus.if_rdata, bus.if_err, busy); end
      n_vec++; if (bus.dm_done !== 1'b0) begin n_err++; $display("FAIL fetch_no_dm_done: got %b want 0", bus.dm_done); end
      tick();
      n_vec++; if (bus.if_done !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL fetch_after: done=%b busy=%b want 0/0", bus.if_done, busy); end
   endtask

   task automatic test_store();
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h0000_0104;
      bus.dm_wdata = 32'hABAD_BABE;
      bus.dm_wmask = 4'b1100;
      bus.dm_req   = 1'b1;
      tick();
      // Change the live inputs; the latched copy must be used.
      bus.dm_wdata = 32'h1111_2222;
      bus.dm_wmask = 4'b0011;
      bus.dm_addr  = 32'h0000_0900;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h104 ||
                      bus.mem_wdata !== 32'hABAD_BABE || bus.mem_wmask !== 4'b1100) begin
            n_err++; $display("FAIL store_stable[%0d]: req=%b we=%b addr=%h wdata=%h wmask=%b want 1/1/104/abadbabe/1100",
                              i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask); end
         if (i < 3) tick();
      end
      ack_man = 1'b1; rdata_man = 32'h5555_AAAA;
      tick();
      ack_man = 1'b0; bus.dm_req = 1'b0;
      n_vec++; if (bus.dm_done !== 1'b1 || bus.if_done !== 1'b0 || bus.dm_err !== 1'b0 || bus.dm_rdata !== 32'h5555_AAAA) begin
         n_err++; $display("FAIL store_done: dm_done=%b if_done=%b err=%b rdata=%h want 1/0/0/5555aaaa",
                           bus.dm_done, bus.if_done, bus.dm_err, bus.dm_rdata); end
      n_vec++; if (bus.if_rdata !== 32'h13) begin n_err++; $display("FAIL store_if_rdata_hold: got %h want 13", bus.if_rdata); end
      tick();
      n_vec++; if (bus.dm_done !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL store_after: done=%b busy=%b want 0/0", bus.dm_done, busy); end
   endtask

   task automatic test_contention();
      int  grants;
      logic prev;
      logic exp_if;
      grants = 0; prev = 1'b0;
      bus.if_addr  = 32'h0000_1000;
      bus.dm_addr  = 32'h0000_2000;
      bus.dm_we    = 1'b0;
      bus.dm_wmask = 4'hF;
      auto_ack     = 1'b1;
      bus.if_req   = 1'b1;
      bus.dm_req   = 1'b1;
      for (int c = 0; c < 80 && grants < 10; c++) begin
         tick();
         if (bus.mem_req === 1'b1 && prev === 1'b0) begin
            exp_if = (grants == 4) || (grants == 9);
            n_vec++; if (bus.mem_addr !== (exp_if ? 32'h1000 : 32'h2000)) begin
               n_err++; $display("FAIL contention_grant[%0d]: addr=%h want %h", grants, bus.mem_addr, exp_if ? 32'h1000 : 32'h2000); end
            n_vec++; if (bus.mem_wmask !== 4'b0000 || bus.mem_we !== 1'b0) begin
               n_err++; $display("FAIL contention_mask[%0d]: wmask=%b we=%b want 0000/0", grants, bus.mem_wmask, bus.mem_we); end
            grants++;
         end
         prev = bus.mem_req;
      end
      n_vec++; if (grants != 10) begin n_err++; $display("FAIL contention_count: got %0d grants want 10", grants); end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      tick(); tick(); tick();
      auto_ack = 1'b0;
      n_vec++; if (bus.if_rdata !== 32'hFFFF_1000 || bus.dm_rdata !== 32'hFFFF_2000) begin
         n_err++; $display("FAIL contention_rdata: if=%h dm=%h want ffff1000/ffff2000", bus.if_rdata, bus.dm_rdata); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL contention_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      int n;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h0000_0300;
      bus.dm_req  = 1'b1;
      tick();
      n = 1;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (bus.mem_req === 1'b1) n++;
         else break;
      end
      n_vec++; if (n != 255) begin n_err++; $display("FAIL timeout_cycles: mem_req high %0d cycles want 255", n); end
      n_vec++; if (bus.dm_done !== 1'b1 || bus.dm_err !== 1'b1 || bus.dm_rdata !== 32'h0) begin
         n_err++; $display("FAIL timeout_done: done=%b err=%b rdata=%h want 1/1/0", bus.dm_done, bus.dm_err, bus.dm_rdata); end
      bus.dm_req = 1'b0;
      tick();
      n_vec++; if (bus.dm_done !== 1'b0 || bus.dm_err !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL timeout_idle: done=%b err=%b busy=%b want 0/0/0", bus.dm_done, bus.dm_err, busy); end
      bus.if_addr = 32'h0000_0040;
      bus.if_req  = 1'b1;
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
         n_err++; $display("FAIL timeout_next_grant: req=%b addr=%h want 1/40", bus.mem_req, bus.mem_addr); end
      ack_man = 1'b1; rdata_man = 32'h0000_0077;
      tick();
      ack_man = 1'b0; bus.if_req = 1'b0;
      n_vec++; if (bus.if_done !== 1'b1 || bus.if_err !== 1'b0 || bus.if_rdata !== 32'h77) begin
         n_err++; $display("FAIL timeout_next_done: done=%b err=%b rdata=%h want 1/0/77", bus.if_done, bus.if_err, bus.if_rdata); end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.dm_we   = 1'b1;
      bus.dm_addr = 32'h0000_0500;
      bus.dm_req  = 1'b1;
      tick();
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL rstmid_busy: req=%b busy=%b want 1/1", bus.mem_req, busy); end
      #2;
      reset = 1'b0;
      #1;
      n_vec++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.dm_done !== 1'b0 || bus.if_done !== 1'b0) begin
         n_err++; $display("FAIL rstmid_async: req=%b busy=%b dm_done=%b if_done=%b want 0/0/0/0",
                           bus.mem_req, busy, bus.dm_done, bus.if_done); end
      n_vec++; if (bus.if_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
         n_err++; $display("FAIL rstmid_clear: if_rdata=%h mem_we=%b want 0/0", bus.if_rdata, bus.mem_we); end
      bus.dm_req = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (bus.dm_done !== 1'b0 || bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.dm_rdata !== 32'h0) begin
            n_err++; $display("FAIL rstmid_late_ack[%0d]: done=%b req=%b busy=%b rdata=%h want 0/0/0/0",
                              i, bus.dm_done, bus.mem_req, busy, bus.dm_rdata); end
      end
      ack_man = 1'b0;
   endtask

   task automatic test_held_request();
      bus.if_addr = 32'h0000_0080;
      bus.if_req  = 1'b1;
      tick();
      n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL held_grant1: req=%b want 1", bus.mem_req); end
      ack_man = 1'b1; rdata_man = 32'h0000_0099;
      tick();
      ack_man = 1'b0;
      n_vec++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h99) begin
         n_err++; $display("FAIL held_done1: done=%b rdata=%h want 1/99", bus.if_done, bus.if_rdata); end
      tick();
      n_vec++; if (bus.if_done !== 1'b0 || busy !== 1'b0 || bus.mem_req !== 1'b0) begin
         n_err++; $display("FAIL held_idle: done=%b busy=%b req=%b want 0/0/0", bus.if_done, busy, bus.mem_req); end
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.if_done !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL held_regrant: req=%b done=%b busy=%b want 1/0/1", bus.mem_req, bus.if_done, busy); end
      ack_man = 1'b1; rdata_man = 32'h0000_00AA;
      tick();
      ack_man = 1'b0; bus.if_req = 1'b0;
      n_vec++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'hAA) begin
         n_err++; $display("FAIL held_done2: done=%b rdata=%h want 1/aa", bus.if_done, bus.if_rdata); end
      tick();
      n_vec++; if (bus.if_done !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL held_end: done=%b busy=%b want 0/0", bus.if_done, busy); end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      auto_ack = 1'b0; ack_man = 1'b0; rdata_man = 32'h0;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0;
      bus.dm_wdata = 32'h0; bus.dm_wmask = 4'h0;
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_timeout();
      test_reset_mid();
      test_held_request();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
